// File: rtl/ldst_sequencer.sv
// Load/store sequencer: splits byte or 2-byte accesses into single-byte data memory cycles.
// Byte loads are zero- or sign-extended; RdData holds the last completed load result.
module ldst_sequencer #(
   parameter int unsigned W = 8,
   parameter int unsigned A = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic           IsStore,
   input  logic           Wide,
   input  logic           Signed,
   input  logic [A-1:0]   Addr,
   input  logic [2*W-1:0] WrData,
   output logic           Busy,
   output logic           Done,
   output logic [2*W-1:0] RdData,
   output logic [A-1:0]   MemAddr,
   output logic           MemWriteEn,
   output logic [W-1:0]   MemWrData,
   input  logic [W-1:0]   MemRdData
);

   typedef enum logic [1:0] {StIdle, StLo, StHi, StFin} state_e;

   state_e         state_q, state_d;
   logic [A-1:0]   addr_q;
   logic [2*W-1:0] wr_data_q;
   logic           is_store_q, wide_q, signed_q;
   logic [W-1:0]   lo_q, hi_q;
   logic [2*W-1:0] rd_data_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wr_data_q  <= '0;
         is_store_q <= 1'b0;
         wide_q     <= 1'b0;
         signed_q   <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && Start) begin
            addr_q     <= Addr;
            wr_data_q  <= WrData;
            is_store_q <= IsStore;
            wide_q     <= Wide;
            signed_q   <= Signed;
         end
         if (state_q == StLo && !is_store_q) lo_q <= MemRdData;
         if (state_q == StHi && !is_store_q) hi_q <= MemRdData;
         if (state_q == StFin && !is_store_q) begin
            if (wide_q) rd_data_q <= {hi_q, lo_q};
            else        rd_data_q <= {{W{signed_q & lo_q[W-1]}}, lo_q};
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      Busy       = 1'b0;
      Done       = 1'b0;
      MemAddr    = '0;
      MemWriteEn = 1'b0;
      MemWrData  = '0;
      unique case (state_q)
         StIdle: if (Start) state_d = StLo;
         StLo: begin
            Busy       = 1'b1;
            MemAddr    = addr_q;
            MemWrData  = wr_data_q[W-1:0];
            MemWriteEn = is_store_q;
            state_d    = wide_q ? StHi : StFin;
         end
         StHi: begin
            Busy       = 1'b1;
            MemAddr    = addr_q + A'(1);  // wraps modulo 2^A
            MemWrData  = wr_data_q[2*W-1:W];
            MemWriteEn = is_store_q;
            state_d    = StFin;
         end
         StFin: begin
            Done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A reset edge must never commit a write, even mid-operation.
      if (Reset) MemWriteEn = 1'b0;
   end

   assign RdData = rd_data_q;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Scoreboard bench for ldst_sequencer with a behavioural 256-byte data memory.
// Stimulus pushes expected latency/result; the monitor checks them on each Done pulse.
module tb_ldst_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start, IsStore, Wide, Signed;
   logic [7:0]  Addr;
   logic [15:0] WrData;
   logic        Busy, Done;
   logic [15:0] RdData;
   logic [7:0]  MemAddr;
   logic        MemWriteEn;
   logic [7:0]  MemWrData;
   logic [7:0]  MemRdData;

   logic [7:0]  mem [256];
   logic        pl_en;
   logic [7:0]  pl_addr, pl_data;

   typedef struct {
      int          start_cyc;
      int          lat;
      bit          chk_rd;
      logic [15:0] rd;
   } exp_t;

   exp_t        sb [$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          we_cnt = 0;
   bit          rd_pending = 0;
   logic [15:0] rd_exp;

   ldst_sequencer #(.W(8), .A(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .IsStore    (IsStore),
      .Wide       (Wide),
      .Signed     (Signed),
      .Addr       (Addr),
      .WrData     (WrData),
      .Busy       (Busy),
      .Done       (Done),
      .RdData     (RdData),
      .MemAddr    (MemAddr),
      .MemWriteEn (MemWriteEn),
      .MemWrData  (MemWrData),
      .MemRdData  (MemRdData)
   );

   always #5 Clk = ~Clk;

   assign MemRdData = mem[MemAddr];

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (MemWriteEn)  mem[MemAddr] <= MemWrData;
      else if (pl_en)  mem[pl_addr] <= pl_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per Done, checks latency and the following RdData.
   always @(negedge Clk) begin
      exp_t e;
      if (rd_pending) begin
         check("rd_data", 32'(RdData), 32'(rd_exp));
         rd_pending = 0;
      end
      if (MemWriteEn) we_cnt++;
      if (Done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            if (e.chk_rd) begin
               rd_pending = 1;
               rd_exp     = e.rd;
            end
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge Clk); #1;
      pl_en = 1'b0;
   endtask

   // Called and returns at #1 after a rising edge, so consecutive calls are back-to-back.
   task automatic do_req(input bit st, input bit wd, input bit sg, input logic [7:0] ad,
                         input logic [15:0] wdat, input int lat, input logic [15:0] rexp,
                         input bit glitch);
      exp_t e;
      int   d0, n;
      d0 = done_cnt;
      Start = 1'b1; IsStore = st; Wide = wd; Signed = sg; Addr = ad; WrData = wdat;
      e.start_cyc = cyc; e.lat = lat; e.chk_rd = !st; e.rd = rexp;
      sb.push_back(e);
      @(posedge Clk); #1;
      Start = glitch; Addr = 8'h00; WrData = 16'h0000; IsStore = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 10) begin
         @(posedge Clk);
         n++;
      end
      if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
      #1;
   endtask

   initial begin
      int we0, d0;
      Reset = 1'b1; Start = 1'b0; IsStore = 1'b0; Wide = 1'b0; Signed = 1'b0;
      Addr = '0; WrData = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_rd_data", 32'(RdData), 32'd0);
      check("rst_we", 32'(MemWriteEn), 32'd0);
      Start = 1'b1;  // Reset must win over Start
      @(posedge Clk); #1;
      check("rst_prio_busy", 32'(Busy), 32'd0);
      Start = 1'b0;
      Reset = 1'b0;
      @(posedge Clk); #1;

      preload(8'h20, 8'h80);
      preload(8'h40, 8'hCD);
      preload(8'h41, 8'hAB);
      preload(8'h50, 8'h00);
      preload(8'h51, 8'h00);

      // Byte store
      we0 = we_cnt;
      do_req(1, 0, 0, 8'h10, 16'h00A5, 2, 16'h0000, 0);
      check("bstore_mem", 32'(mem[8'h10]), 32'hA5);
      check("bstore_we_cnt", 32'(we_cnt - we0), 32'd1);

      // Wide store across the address wrap
      we0 = we_cnt;
      do_req(1, 1, 0, 8'hFF, 16'h1234, 3, 16'h0000, 0);
      check("wstore_mem_ff", 32'(mem[8'hFF]), 32'h34);
      check("wstore_mem_00", 32'(mem[8'h00]), 32'h12);
      check("wstore_we_cnt", 32'(we_cnt - we0), 32'd2);

      // Byte loads, signed and unsigned
      do_req(0, 0, 1, 8'h20, 16'h0000, 2, 16'hFF80, 0);
      do_req(0, 0, 0, 8'h20, 16'h0000, 2, 16'h0080, 0);

      // Wide load with Start pulsed while Busy; Signed ignored
      we0 = we_cnt;
      do_req(0, 1, 1, 8'h40, 16'h0000, 3, 16'hABCD, 1);
      d0 = done_cnt;
      repeat (4) @(posedge Clk);
      #1;
      check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
      check("glitch_idle", 32'(Busy), 32'd0);
      check("load_no_we", 32'(we_cnt - we0), 32'd0);

      // Back-to-back: store then load of the same location
      do_req(1, 0, 0, 8'h60, 16'hFF7F, 2, 16'h0000, 0);
      do_req(0, 0, 1, 8'h60, 16'h0000, 2, 16'h007F, 0);
      do_req(1, 1, 0, 8'h70, 16'h9A5C, 3, 16'h0000, 0);
      do_req(0, 1, 0, 8'h70, 16'h0000, 3, 16'h9A5C, 0);
      check("store_keeps_rd", 32'(RdData), 32'h9A5C);

      // Reset in HI of a wide store: low byte written, high byte not, no Done
      @(posedge Clk); #1;
      d0 = done_cnt; we0 = we_cnt;
      Start = 1'b1; IsStore = 1'b1; Wide = 1'b1; Addr = 8'h50; WrData = 16'hBEEF;
      @(posedge Clk); #1;
      Start = 1'b0;
      @(posedge Clk); #1;
      check("hi_we_before_rst", 32'(MemWriteEn), 32'd1);
      Reset = 1'b1;
      #1;
      check("rst_we_forced", 32'(MemWriteEn), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      check("rst_mid_busy", 32'(Busy), 32'd0);
      check("rst_mid_rd_data", 32'(RdData), 32'd0);
      repeat (5) @(posedge Clk);
      #1;
      check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
      check("rst_mid_lo_mem", 32'(mem[8'h50]), 32'hEF);
      check("rst_mid_hi_mem", 32'(mem[8'h51]), 32'h00);
      check("rst_mid_we_cnt", 32'(we_cnt - we0), 32'd1);

      // Recovery after abandoned request
      do_req(0, 0, 0, 8'h50, 16'h0000, 2, 16'h00EF, 0);
      @(posedge Clk); #1;
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
